dc_mib_rx: RTL and testbench

//  Data-path-side receiver for the microinstruction bus (MIB) driven by the control chip.

---
 rtl/dc_mib_pkg.sv | 53 +++++
 rtl/dc_mib_if.sv | 25 ++
 rtl/dc_mib_bus.sv | 98 +++++++++
 rtl/dc_mib_rx.sv | 86 ++++++++
 tb/tb_dc_mib_rx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/dc_mib_pkg.sv
// Shared MIB receiver definitions: class codes, condition encodings, flag indices, bus FSM states.
// Build option DC_MIB_TMO_EN (bus timeout) is consumed by dc_mib_bus and dc_mib_rx.
package dc_mib_pkg;

  localparam logic [4:0] MIB_JMP  = 5'b00000;
  localparam logic [4:0] MIB_CJMP = 5'b00001;
  localparam logic [2:0] MIB_BUS  = 3'b111;

  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_V = 1;
  localparam int unsigned FLG_C = 0;

  typedef enum logic [2:0] {
    COND_Z   = 3'd0,
    COND_N   = 3'd1,
    COND_C   = 3'd2,
    COND_V   = 3'd3,
    COND_NV  = 3'd4,
    COND_ZNV = 3'd5,
    COND_CZ  = 3'd6,
    COND_T   = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bus_state_e;

  function automatic logic is_bus_op(input logic [15:0] w);
    return w[15:13] == MIB_BUS;
  endfunction

  function automatic logic cond_eval(input logic [2:0] sel, input logic [3:0] f);
    logic res;
    res = 1'b0;
    case (cond_e'(sel))
      COND_Z:   res = f[FLG_Z];
      COND_N:   res = f[FLG_N];
      COND_C:   res = f[FLG_C];
      COND_V:   res = f[FLG_V];
      COND_NV:  res = f[FLG_N] ^ f[FLG_V];
      COND_ZNV: res = f[FLG_Z] | (f[FLG_N] ^ f[FLG_V]);
      COND_CZ:  res = f[FLG_C] | f[FLG_Z];
      COND_T:   res = 1'b1;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dc_mib_if.sv
// MIB receiver pin bundle: control-chip side (master) and data-path receiver side (slave).
interface dc_mib_if;
  logic        pin_mce_p;
  logic        pin_mce_n;
  logic [15:0] pin_m;
  logic [3:0]  pin_flg;
  logic        pin_rply;
  logic [15:0] pin_mc;
  logic        pin_bra;
  logic        pin_sync;
  logic        pin_din;
  logic        pin_dout;
  logic        pin_stall;
  logic        pin_bto;

  modport master (
    output pin_mce_p, pin_mce_n, pin_m, pin_flg, pin_rply,
    input  pin_mc, pin_bra, pin_sync, pin_din, pin_dout, pin_stall, pin_bto
  );

  modport slave (
    input  pin_mce_p, pin_mce_n, pin_m, pin_flg, pin_rply,
    output pin_mc, pin_bra, pin_sync, pin_din, pin_dout, pin_stall, pin_bto
  );
endinterface

// File: rtl/dc_mib_bus.sv
// Bus-cycle sequencer: SYNC/DIN/DOUT strobes, MIB stall and optional RPLY timeout.
// DC_MIB_TMO_EN builds the timeout counter and sticky bto; otherwise DATA waits for RPLY forever.
module dc_mib_bus
  import dc_mib_pkg::*;
`ifdef DC_MIB_TMO_EN
#(
  parameter int unsigned TMO_CYCLES = 64
)
`endif
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic mce_p_i,
  input  logic start_i,
  input  logic wr_i,
  input  logic rply_i,
  output logic sync_o,
  output logic din_o,
  output logic dout_o,
  output logic stall_o,
  output logic bto_o
);

  bus_state_e state_q;
  logic       sync_q, din_q, dout_q, stall_q;

`ifdef DC_MIB_TMO_EN
  localparam int unsigned CW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          bto_q;
`endif

  // Counter only advances below CNT_LAST, so it saturates instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sync_q  <= 1'b0;
      din_q   <= 1'b0;
      dout_q  <= 1'b0;
      stall_q <= 1'b0;
`ifdef DC_MIB_TMO_EN
      cnt_q   <= '0;
      bto_q   <= 1'b0;
`endif
    end else if (mce_p_i) begin
      unique case (state_q)
        IDLE: if (start_i) begin
          state_q <= ADDR;
          sync_q  <= 1'b1;
          stall_q <= 1'b1;
`ifdef DC_MIB_TMO_EN
          bto_q   <= 1'b0;
          cnt_q   <= '0;
`endif
        end
        ADDR: begin
          state_q <= DATA;
          din_q   <= ~wr_i;
          dout_q  <= wr_i;
        end
        DATA: begin
          if (rply_i) begin
            state_q <= DONE;
          end
`ifdef DC_MIB_TMO_EN
          else if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            bto_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
          sync_q  <= 1'b0;
          din_q   <= 1'b0;
          dout_q  <= 1'b0;
          stall_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sync_o  = sync_q;
  assign din_o   = din_q;
  assign dout_o  = dout_q;
  assign stall_o = stall_q;
`ifdef DC_MIB_TMO_EN
  assign bto_o   = bto_q;
`else
  assign bto_o   = 1'b0;
`endif

endmodule

// File: rtl/dc_mib_rx.sv
// MIB receiver top: microinstruction latch, NZVC flags and conditional-branch return.
// DC_MIB_TMO_EN enables the bus timeout (TMO_CYCLES) in the dc_mib_bus sequencer.
module dc_mib_rx
  import dc_mib_pkg::*;
`ifdef DC_MIB_TMO_EN
#(
  parameter int unsigned TMO_CYCLES = 64
)
`endif
(
  input logic     pin_clk,
  input logic     pin_rst,
  dc_mib_if.slave mib
);

  logic [15:0] mc_q, mc_d;
  logic [3:0]  flg_q, flg_d;
  logic        bra_q, bra_d;
  logic        stall, start;
  logic        is_jmp, is_cjmp, is_bus, is_alu;
  logic        sync, din, dout, bto;

  assign is_jmp  = mc_q[15:11] == MIB_JMP;
  assign is_cjmp = mc_q[15:11] == MIB_CJMP;
  assign is_bus  = is_bus_op(mc_q);
  assign is_alu  = ~(is_jmp | is_cjmp | is_bus);

  // A bus op starts on the very edge that latches it, so the latch is frozen from then on.
  assign start = mib.pin_mce_p & ~stall & is_bus_op(mib.pin_m);

  always_comb begin
    mc_d  = mc_q;
    flg_d = flg_q;
    bra_d = bra_q;
    if (mib.pin_mce_p && !stall) begin
      mc_d = mib.pin_m;
    end
    if (mib.pin_mce_n) begin
      if (!stall) begin
        bra_d = ~(is_cjmp & cond_eval(mc_q[10:8], flg_q));
      end
      if (is_alu && mc_q[3]) begin
        flg_d = mib.pin_flg;
      end
    end
  end

  always_ff @(posedge pin_clk or posedge pin_rst) begin
    if (pin_rst) begin
      mc_q  <= '0;
      flg_q <= '0;
      bra_q <= 1'b1;
    end else begin
      mc_q  <= mc_d;
      flg_q <= flg_d;
      bra_q <= bra_d;
    end
  end

`ifdef DC_MIB_TMO_EN
  dc_mib_bus #(.TMO_CYCLES(TMO_CYCLES)) u_bus (
`else
  dc_mib_bus u_bus (
`endif
    .clk_i   (pin_clk),
    .rst_i   (pin_rst),
    .mce_p_i (mib.pin_mce_p),
    .start_i (start),
    .wr_i    (mc_q[12]),
    .rply_i  (mib.pin_rply),
    .sync_o  (sync),
    .din_o   (din),
    .dout_o  (dout),
    .stall_o (stall),
    .bto_o   (bto)
  );

  assign mib.pin_mc    = mc_q;
  assign mib.pin_bra   = bra_q;
  assign mib.pin_sync  = sync;
  assign mib.pin_din   = din;
  assign mib.pin_dout  = dout;
  assign mib.pin_stall = stall;
  assign mib.pin_bto   = bto;

endmodule

// File: tb/tb_dc_mib_rx.sv
// Self-checking bench for dc_mib_rx: directed scenarios plus random MIB traffic against a
// transaction-level model. Honours DC_MIB_TMO_EN (timeout model active, TMO_CYCLES=4).
module tb_dc_mib_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dc_mib_if mib();

`ifdef DC_MIB_TMO_EN
  localparam int TMO = 4;
  dc_mib_rx #(.TMO_CYCLES(TMO)) dut (.pin_clk(clk), .pin_rst(rst), .mib(mib));
`else
  dc_mib_rx dut (.pin_clk(clk), .pin_rst(rst), .mib(mib));
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a bus cycle is tracked as the number of mce_p edges since it was accepted.
  logic [15:0] e_mc;
  logic [3:0]  e_flg;
  logic        e_bra, e_act, e_end, e_wr, e_bto;
  int          e_j;

  localparam logic [15:0] W = 16'o012345;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(input int sel, input logic [3:0] f);
    bit n, z, v, c;
    {n, z, v, c} = f;
    case (sel)
      0: return z;
      1: return n;
      2: return c;
      3: return v;
      4: return n != v;
      5: return z || (n != v);
      6: return c || z;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    e_mc = '0; e_flg = '0; e_bra = 1'b1;
    e_act = 1'b0; e_end = 1'b0; e_wr = 1'b0; e_bto = 1'b0; e_j = 0;
  endtask

  task automatic model_p(input logic [15:0] m, input logic rply);
    if (!e_act) begin
      e_mc = m;
      if (m[15:13] == 3'b111) begin
        e_act = 1'b1; e_j = 0; e_end = 1'b0; e_wr = m[12]; e_bto = 1'b0;
      end
    end else begin
      e_j++;
      if (e_end) e_act = 1'b0;
      else if (e_j >= 2) begin
        if (rply) e_end = 1'b1;
`ifdef DC_MIB_TMO_EN
        else if (e_j - 1 == TMO) begin
          e_end = 1'b1;
          e_bto = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic model_n(input logic [3:0] flg);
    bit cjmp, bus, alu;
    cjmp = e_mc[15:11] == 5'd1;
    bus  = e_mc[15:13] == 3'd7;
    alu  = (e_mc[15:11] != 5'd0) && !cjmp && !bus;
    if (!e_act) e_bra = !(cjmp && cond_ok(int'(e_mc[10:8]), e_flg));
    if (alu && e_mc[3]) e_flg = flg;
  endtask

  task automatic check_all(input string ph);
    bit data_ph;
    data_ph = e_act && (e_j >= 1);
    chk({ph, "_mc"},    mib.pin_mc,             e_mc);
    chk({ph, "_bra"},   16'(mib.pin_bra),       16'(e_bra));
    chk({ph, "_sync"},  16'(mib.pin_sync),      16'(e_act));
    chk({ph, "_stall"}, 16'(mib.pin_stall),     16'(e_act));
    chk({ph, "_din"},   16'(mib.pin_din),       16'(data_ph && !e_wr));
    chk({ph, "_dout"},  16'(mib.pin_dout),      16'(data_ph && e_wr));
    chk({ph, "_bto"},   16'(mib.pin_bto),       16'(e_bto));
  endtask

  // One MIB period: mce_p pulse, check, mce_n pulse, check, optional idle gap.
  task automatic step(input logic [15:0] m, input logic [3:0] flg, input logic rply);
    @(negedge clk);
    mib.pin_m = m; mib.pin_flg = flg; mib.pin_rply = rply; mib.pin_mce_p = 1'b1;
    model_p(m, rply);
    @(negedge clk);
    mib.pin_mce_p = 1'b0;
    check_all("p");
    mib.pin_mce_n = 1'b1;
    model_n(flg);
    @(negedge clk);
    mib.pin_mce_n = 1'b0;
    check_all("n");
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 4))
      0: w[15:11] = 5'b00000;
      1: w[15:11] = 5'b00001;
      2: w[15:13] = 3'b111;
      default: if (w[15:12] == 4'b0000 || w[15:13] == 3'b111) w[15:13] = 3'b010;
    endcase
    return w;
  endfunction

  initial begin
    mib.pin_mce_p = 1'b0; mib.pin_mce_n = 1'b0;
    mib.pin_m = '0; mib.pin_flg = '0; mib.pin_rply = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("rst");
    rst = 1'b0;

    step(16'o010010, 4'b0100, 1'b0);
    step(16'o004000, 4'b0000, 1'b0);
    chk("cjmp_z_mc", mib.pin_mc, 16'o004000);
    chk("cjmp_z_taken", 16'(mib.pin_bra), 16'd0);
    step(16'o010010, 4'b0000, 1'b0);
    step(16'o004000, 4'b1111, 1'b0);
    chk("cjmp_z_not", 16'(mib.pin_bra), 16'd1);

    step(16'o010010, 4'b1000, 1'b0);
    step(16'o006000, 4'b0000, 1'b0);
    chk("cjmp_nv_taken", 16'(mib.pin_bra), 16'd0);
    step(16'o010000, 4'b0000, 1'b0);
    step(16'o006000, 4'b0000, 1'b0);
    chk("alu_noload", 16'(mib.pin_bra), 16'd0);

    step(16'o160000, 4'b0000, 1'b0);
    chk("rd_addr_sync", 16'(mib.pin_sync), 16'd1);
    step(W, 4'b0000, 1'b0);
    chk("rd_data_din", 16'(mib.pin_din), 16'd1);
    step(W, 4'b0000, 1'b0);
    step(W, 4'b0000, 1'b0);
    step(W, 4'b0000, 1'b1);
    chk("rd_done_stall", 16'(mib.pin_stall), 16'd1);
    chk("rd_done_mc", mib.pin_mc, 16'o160000);
    step(W, 4'b0000, 1'b0);
    chk("rd_idle_mc", mib.pin_mc, 16'o160000);
    step(W, 4'b0000, 1'b0);
    chk("rd_next_mc", mib.pin_mc, W);

`ifdef DC_MIB_TMO_EN
    step(16'o170000, 4'b0000, 1'b0);
    repeat (5) step(W, 4'b0000, 1'b0);
    chk("tmo_bto", 16'(mib.pin_bto), 16'd1);
    step(W, 4'b0000, 1'b0);
    chk("tmo_bto_sticky", 16'(mib.pin_bto), 16'd1);
    step(16'o160000, 4'b0000, 1'b0);
    chk("tmo_bto_clr", 16'(mib.pin_bto), 16'd0);
    step(W, 4'b0000, 1'b0);
    step(W, 4'b0000, 1'b1);
    step(W, 4'b0000, 1'b0);

    step(16'o170000, 4'b0000, 1'b0);
    repeat (4) step(W, 4'b0000, 1'b0);
    step(W, 4'b0000, 1'b1);
    chk("tmo_rply_wins", 16'(mib.pin_bto), 16'd0);
    step(W, 4'b0000, 1'b0);
`else
    step(16'o170000, 4'b0000, 1'b0);
    repeat (200) step(W, 4'b0000, 1'b0);
    chk("notmo_dout", 16'(mib.pin_dout), 16'd1);
    chk("notmo_bto", 16'(mib.pin_bto), 16'd0);
    step(W, 4'b0000, 1'b1);
    step(W, 4'b0000, 1'b0);
`endif

    step(16'o160000, 4'b0000, 1'b0);
    step(W, 4'b0000, 1'b0);
    step(W, 4'b0000, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("arst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      step(rand_word(), 4'($urandom), $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
